// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage vs host/debug port, one multi-cycle access at a time.
// Optional ARB_PERF_EN adds CPU grant and stall-cycle performance counters.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_cpu_grants,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);
  localparam logic [3:0] LatLast = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
  typedef enum logic {OwnCpu, OwnDbg} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        lat_q, lat_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;

  logic grant_cpu, grant_dbg, lat_last;
  logic cpu_done_c, dbg_done_c;

  // Only the word-address bits reach memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                              dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

  // Debug jumps the queue only once the CPU has taken STARVE_LIMIT grants in front of it.
  always_comb begin
    grant_dbg = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == StIdle) begin
      grant_dbg = dbg_req & (~cpu_req | (starve_q == StarveMax));
      grant_cpu = cpu_req & ~grant_dbg;
    end
  end

  assign lat_last = (state_q == StAccess) && (lat_q == LatLast);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cpu_req || dbg_req) state_d = StAccess;
      StAccess: if (lat_last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    mem_en     = (state_q == StAccess) && (lat_q == 4'd0);
    mem_we     = mem_en & we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    cpu_done_c = (state_q == StDone) && (owner_q == OwnCpu);
    dbg_done_c = (state_q == StDone) && (owner_q == OwnDbg);
    cpu_done   = cpu_done_c;
    dbg_done   = dbg_done_c;
    cpu_stall  = cpu_req & ~cpu_done_c;
    cpu_rdata  = cpu_rdata_q;
    dbg_rdata  = dbg_rdata_q;
  end

  // Datapath next-state: request latch, latency and starvation counters, read capture
  always_comb begin
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    starve_d    = starve_q;
    lat_d       = 4'd0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    if (grant_dbg) begin
      owner_d  = OwnDbg;
      we_d     = dbg_we;
      addr_d   = dbg_addr[ADDR_W+1:2];
      wdata_d  = dbg_wdata;
      starve_d = '0;
    end else if (grant_cpu) begin
      owner_d = OwnCpu;
      we_d    = cpu_we;
      addr_d  = cpu_addr[ADDR_W+1:2];
      wdata_d = cpu_wdata;
      if (dbg_req && (starve_q != StarveMax)) starve_d = starve_q + SW'(1);
    end

    if (state_q == StAccess) lat_d = lat_last ? 4'd0 : lat_q + 4'd1;

    if (lat_last && !we_q) begin
      if (owner_q == OwnCpu) cpu_rdata_d = mem_rdata;
      else                   dbg_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= OwnCpu;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= 4'd0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

`ifdef ARB_PERF_EN
  logic [31:0] perf_grants_q, perf_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_grants_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (grant_cpu) perf_grants_q <= perf_grants_q + 32'd1;
      if (cpu_stall) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cpu_grants   = perf_grants_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table plus multi-cycle sequences.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W       = 10;
  localparam int unsigned MEM_LAT      = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0]       cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0]       cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic              cpu_done, cpu_stall, dbg_done, mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
`ifdef ARB_PERF_EN
  logic [31:0]       perf_cpu_grants, perf_stall_cycles;
`endif

  dmem_arbiter #(
    .ADDR_W      (ADDR_W),
    .MEM_LAT     (MEM_LAT),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_done (cpu_done),
    .cpu_stall(cpu_stall),
    .dbg_req  (dbg_req),
    .dbg_we   (dbg_we),
    .dbg_addr (dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata),
    .dbg_done (dbg_done),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
    ,
    .perf_cpu_grants  (perf_cpu_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: read data registered at the strobe edge and held until the next strobe.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      rd_q <= mem[mem_addr];
    end
  end
  assign mem_rdata = rd_q;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [127:0] outs;
    outs = {17'b0, cpu_rdata, cpu_done, cpu_stall, dbg_rdata, dbg_done,
            mem_en, mem_we, mem_addr, mem_wdata};
    check(name, outs, 128'd0);
  endtask

  int                r_lat, r_stalls, r_strobes, r_other;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [31:0]       r_wdata, r_rdata;

  // One access by one requester; counts cycles from the request cycle (k=0) to done.
  task automatic do_access(input logic is_dbg, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    @(negedge clk);
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    r_lat = -1; r_stalls = 0; r_strobes = 0; r_other = 0;
    r_addr = '0; r_we = 1'b0; r_wdata = '0; r_rdata = '0;
    #1;
    r_stalls += int'(cpu_stall);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_en) begin
        r_strobes++;
        r_addr = mem_addr; r_we = mem_we; r_wdata = mem_wdata;
      end
      if (is_dbg ? cpu_done : dbg_done) r_other++;
      r_stalls += int'(cpu_stall);
      if (is_dbg ? dbg_done : cpu_done) begin
        r_lat = k;
        r_rdata = is_dbg ? dbg_rdata : cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  typedef struct {
    logic              is_dbg;
    logic              we;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] exp_maddr;
    logic [31:0]       exp_rdata;
  } vec_t;

  vec_t vecs[7];

  int   cpu_at, dbg_at, both, n, last_k, dones;
  logic [31:0] cpu_rd, dbg_rd;
  logic [5:0]  order;

  initial begin
    // rdata expectation for writes is the value the port must keep holding
    vecs[0] = '{1'b1, 1'b1, 32'h0000_000C, 32'd10,        10'd3, 32'd0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_000C, 32'd0,         10'd3, 32'd10};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_001C, 32'd89,        10'd7, 32'd10};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_001C, 32'd0,         10'd7, 32'd89};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_1010, 32'hA5A5_0001, 10'd4, 32'd89};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0013, 32'd0,         10'd4, 32'hA5A5_0001};
    vecs[6] = '{1'b0, 1'b0, 32'hFFFF_F00C, 32'd0,         10'd3, 32'd10};

    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_outputs");
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_access(vecs[i].is_dbg, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d_latency", i), 128'(r_lat), 128'(MEM_LAT + 1));
      check($sformatf("v%0d_strobes", i), 128'(r_strobes), 128'd1);
      check($sformatf("v%0d_mem_addr", i), 128'(r_addr), 128'(vecs[i].exp_maddr));
      check($sformatf("v%0d_mem_we", i), 128'(r_we), 128'(vecs[i].we));
      if (vecs[i].we) check($sformatf("v%0d_mem_wdata", i), 128'(r_wdata), 128'(vecs[i].wdata));
      check($sformatf("v%0d_rdata", i), 128'(r_rdata), 128'(vecs[i].exp_rdata));
      check($sformatf("v%0d_stall_cycles", i), 128'(r_stalls),
            vecs[i].is_dbg ? 128'd0 : 128'(MEM_LAT + 1));
      check($sformatf("v%0d_other_done", i), 128'(r_other), 128'd0);
    end

    // Simultaneous requests: CPU first, debug right behind it.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1C;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0C;
    cpu_at = -1; dbg_at = -1; both = 0; cpu_rd = '0; dbg_rd = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (cpu_done && dbg_done) both++;
      if (cpu_done && cpu_at < 0) begin cpu_at = k; cpu_rd = cpu_rdata; cpu_req = 1'b0; end
      if (dbg_done && dbg_at < 0) begin dbg_at = k; dbg_rd = dbg_rdata; dbg_req = 1'b0; end
      if (cpu_at > 0 && dbg_at > 0) break;
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("simul_cpu_done_cycle", 128'(cpu_at), 128'd3);
    check("simul_dbg_done_cycle", 128'(dbg_at), 128'd7);
    check("simul_cpu_rdata", 128'(cpu_rd), 128'd89);
    check("simul_dbg_rdata", 128'(dbg_rd), 128'd10);
    check("simul_both_done", 128'(both), 128'd0);

    // Starvation: CPU holds its request; debug gets in after STARVE_LIMIT CPU grants.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1C;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0C;
    order = '0; n = 0; last_k = -1; both = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (cpu_done && dbg_done) both++;
      if (dbg_done) begin
        order[n] = 1'b1; n++; dbg_req = 1'b0;
      end else if (cpu_done) begin
        n++;
      end
      if (n == 6) begin last_k = k; break; end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("starve_grant_count", 128'(n), 128'd6);
    check("starve_grant_order", 128'(order), 128'(6'b010000));
    check("starve_sixth_done_cycle", 128'(last_k), 128'd23);
    check("starve_both_done", 128'(both), 128'd0);

    // Reset in the second ACCESS cycle of a debug read.
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0C;
    repeat (2) @(negedge clk);
    check("abort_in_second_access", 128'({mem_en, dbg_done}), 128'd0);
    reset = 1'b1;
    dbg_req = 1'b0;
    #1;
    check_outputs_zero("abort_outputs_zero");
    dones = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      dones += int'(cpu_done) + int'(dbg_done) + int'(mem_en);
    end
    check("abort_no_activity", 128'(dones), 128'd0);
    do_access(1'b1, 1'b0, 32'h0C, 32'd0);
    check("after_abort_latency", 128'(r_lat), 128'(MEM_LAT + 1));
    check("after_abort_rdata", 128'(r_rdata), 128'd10);

    // Three CPU reads after reset.
    for (int i = 0; i < 3; i++) begin
      do_access(1'b0, 1'b0, 32'h1C, 32'd0);
      check($sformatf("cpu_read%0d_rdata", i), 128'(r_rdata), 128'd89);
    end
`ifdef ARB_PERF_EN
    @(negedge clk);
    check("perf_cpu_grants", 128'(perf_cpu_grants), 128'd3);
    check("perf_stall_cycles", 128'(perf_stall_cycles), 128'd9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary, got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
